// File: rtl/cpu_mem_loader_if.sv
// Boot-load stream and CPU memory bus between cpu_mem_loader and its neighbours.
// The slave side is the loader/memory; master drives bytes and CPU accesses.
interface cpu_mem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic [ADDR_W-1:0] adr_bus;
  logic              rd_mem;
  logic              wr_mem;
  logic [DATA_W-1:0] d_out;
  logic [DATA_W-1:0] d_in;

  modport master (
    output ld_valid, ld_data, ld_last,
    output adr_bus, rd_mem, wr_mem, d_out,
    input  ld_ready, d_in
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    input  adr_bus, rd_mem, wr_mem, d_out,
    output ld_ready, d_in
  );
endinterface

// File: rtl/cpu_mem_loader.sv
// Boot loader + 2^ADDR_W x DATA_W memory feeding the CPU bus.
// Optional MEM_WRITE_PROTECT_EN: RUN writes below load_cnt are dropped, wp_err flags.
module cpu_mem_loader #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int LOAD_LEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  cpu_mem_loader_if.slave   bus,
  output logic              cpu_reset,
  output logic              run,
  output logic [ADDR_W:0]   load_cnt
`ifdef MEM_WRITE_PROTECT_EN
  ,
  output logic              wp_err
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_LOAD,
    S_REL,
    S_RUN
  } state_e;

  state_e state_q, state_d;

  logic              ld_ready_q, ld_ready_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] d_in_q, d_in_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              last_acc;
  logic              run_wr;
  logic              wr_ok;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  assign accept   = (state_q == S_LOAD) & bus.ld_valid & ld_ready_q;
  assign last_acc = accept &
    (bus.ld_last | (cnt_q == (ADDR_W+1)'(LOAD_LEN - 1)));
  assign run_wr   = (state_q == S_RUN) & bus.wr_mem;

`ifdef MEM_WRITE_PROTECT_EN
  logic wp_q, wp_d;
  assign wr_ok = {1'b0, bus.adr_bus} >= cnt_q;
  assign wp_d  = wp_q | (run_wr & ~wr_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wp_q <= 1'b0;
    else        wp_q <= wp_d;
  end

  assign wp_err = wp_q;
`else
  assign wr_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:  if (last_acc) state_d = S_REL;
      S_REL:   state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    ld_ready_d = (state_d == S_LOAD);
    cnt_d      = cnt_q + {{ADDR_W{1'b0}}, accept};
    d_in_d     = d_in_q;
    we         = 1'b0;
    waddr      = cnt_q[ADDR_W-1:0];
    wdata      = bus.ld_data;
    if (accept) begin
      we = 1'b1;
    end else if (run_wr & wr_ok) begin
      we    = 1'b1;
      waddr = bus.adr_bus;
      wdata = bus.d_out;
    end
    // A simultaneous write takes the cycle; the read is dropped
    if ((state_q == S_RUN) & bus.rd_mem & ~bus.wr_mem)
      d_in_d = mem_q[bus.adr_bus];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_ready_q <= 1'b0;
      cnt_q      <= '0;
      d_in_q     <= '0;
    end else begin
      ld_ready_q <= ld_ready_d;
      cnt_q      <= cnt_d;
      d_in_q     <= d_in_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.d_in     = d_in_q;
  assign cpu_reset    = (state_q != S_RUN);
  assign run          = (state_q == S_RUN);
  assign load_cnt     = cnt_q;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Directed bench for cpu_mem_loader (LOAD_LEN=4) with a per-cycle reference model.
// Honours MEM_WRITE_PROTECT_EN when the build defines it.
module tb_cpu_mem_loader;

  localparam int AW  = 6;
  localparam int DW  = 8;
  localparam int LEN = 4;
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_reset;
  logic          run;
  logic [AW:0]   load_cnt;
  logic          wp_flag;

  int checks   = 0;
  int failures = 0;

  cpu_mem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MEM_WRITE_PROTECT_EN
  cpu_mem_loader #(.ADDR_W(AW), .DATA_W(DW), .LOAD_LEN(LEN)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cpu_reset(cpu_reset), .run(run), .load_cnt(load_cnt),
    .wp_err(wp_flag)
  );
`else
  cpu_mem_loader #(.ADDR_W(AW), .DATA_W(DW), .LOAD_LEN(LEN)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cpu_reset(cpu_reset), .run(run), .load_cnt(load_cnt)
  );
  assign wp_flag = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference model: phase 0=load, 1=release, 2=run
  logic [7:0] m_mem [64];
  int         m_phase;
  int         m_cnt;
  bit         m_ready;
  logic [7:0] m_din;
  bit         m_wp;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_ready <= 1'b0;
      m_din   <= 8'h00;
      m_wp    <= 1'b0;
      for (int i = 0; i < 64; i++) m_mem[i] <= 8'h00;
    end else begin
      case (m_phase)
        0: begin
          if (bus.ld_valid && m_ready) begin
            m_mem[m_cnt] <= bus.ld_data;
            m_cnt <= m_cnt + 1;
            if (bus.ld_last || (m_cnt + 1 == LEN)) begin
              m_phase <= 1;
              m_ready <= 1'b0;
            end
          end else begin
            m_ready <= 1'b1;
          end
        end
        1: m_phase <= 2;
        default: begin
          if (bus.wr_mem) begin
            if (WP_ON && (int'(bus.adr_bus) < m_cnt)) m_wp <= 1'b1;
            else m_mem[bus.adr_bus] <= bus.d_out;
          end else if (bus.rd_mem) begin
            m_din <= m_mem[bus.adr_bus];
          end
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_ld_ready", 32'(bus.ld_ready), 32'(m_ready));
    chk("cyc_load_cnt", 32'(load_cnt), m_cnt);
    chk("cyc_cpu_reset", 32'(cpu_reset), 32'(m_phase != 2));
    chk("cyc_run", 32'(run), 32'(m_phase == 2));
    chk("cyc_d_in", 32'(bus.d_in), 32'(m_din));
    chk("cyc_wp_err", 32'(wp_flag), 32'(m_wp));
  end

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld_valid = 1'b0;
    bus.ld_data  = 8'h00;
    bus.ld_last  = 1'b0;
    bus.adr_bus  = '0;
    bus.rd_mem   = 1'b0;
    bus.wr_mem   = 1'b0;
    bus.d_out    = 8'h00;
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_ld_ready"}, 32'(bus.ld_ready), 0);
    chk({tag, "_load_cnt"}, 32'(load_cnt), 0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 1);
    chk({tag, "_run"}, 32'(run), 0);
    chk({tag, "_d_in"}, 32'(bus.d_in), 0);
    chk({tag, "_wp_err"}, 32'(wp_flag), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    rst_check(tag);
    idle();
    cycle();
    reset = 1'b1;
    cycle();
  endtask

  task automatic rd(input int a, input logic [7:0] exp, input string name);
    bus.adr_bus = AW'(a);
    bus.rd_mem  = 1'b1;
    bus.wr_mem  = 1'b0;
    cycle();
    bus.rd_mem  = 1'b0;
    chk(name, 32'(bus.d_in), 32'(exp));
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    bus.adr_bus = AW'(a);
    bus.d_out   = d;
    bus.wr_mem  = 1'b1;
    bus.rd_mem  = 1'b0;
    cycle();
    bus.wr_mem  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         vv [7];
    logic [7:0] gexp [5];
    vv   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    gexp = '{8'hA1, 8'hA3, 8'hA4, 8'hA6, 8'h00};

    reset = 1'b1;
    idle();
    #1 reset = 1'b0;
    #1;
    rst_check("por");
    cycle();
    reset = 1'b1;
    cycle();
    chk("ready_after_release", 32'(bus.ld_ready), 1);

    // Three-byte load ending on ld_last
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h11;
    cycle();
    bus.ld_data  = 8'h22;
    cycle();
    bus.ld_data  = 8'h33;
    bus.ld_last  = 1'b1;
    cycle();
    idle();
    chk("t1_cnt", 32'(load_cnt), 3);
    chk("t1_release_cpu_reset", 32'(cpu_reset), 1);
    chk("t1_ready_dropped", 32'(bus.ld_ready), 0);
    cycle();
    chk("t1_run_cpu_reset", 32'(cpu_reset), 0);
    chk("t1_run", 32'(run), 1);
    rd(2, 8'h33, "t1_rd2");
    rd(5, 8'h00, "t1_rd5");

    // RUN write/read and rd+wr collision
    wr(40, 8'hA5);
    rd(40, 8'hA5, "raw_40");
    bus.adr_bus = 6'd41;
    bus.d_out   = 8'h5A;
    bus.wr_mem  = 1'b1;
    bus.rd_mem  = 1'b1;
    cycle();
    idle();
    chk("rdwr_hold", 32'(bus.d_in), 32'h A5);
    rd(41, 8'h5A, "rd_41");

    wr(1, 8'hFF);
`ifdef MEM_WRITE_PROTECT_EN
    chk("wp_set", 32'(wp_flag), 1);
    rd(1, 8'h22, "wp_protected");
`else
    rd(1, 8'hFF, "nowp_write1");
`endif
    wr(10, 8'h77);
    rd(10, 8'h77, "wr_10");

    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hEE;
    cycle();
    idle();
    chk("run_ignores_ld", 32'(load_cnt), 3);

    do_reset("rst_run");

    // Gapped stream hitting LOAD_LEN
    for (int i = 0; i < 7; i++) begin
      bus.ld_valid = vv[i];
      bus.ld_data  = 8'hA1 + 8'(i);
      cycle();
      if (i == 5) begin
        chk("len_cnt", 32'(load_cnt), LEN);
        chk("len_ready_low", 32'(bus.ld_ready), 0);
      end
    end
    idle();
    cycle();
    chk("len_cnt_final", 32'(load_cnt), LEN);
    for (int k = 0; k < 5; k++) rd(k, gexp[k], "gap_rd");

    // Reset mid-load, then reload from address 0
    do_reset("rst_run2");
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hB1;
    cycle();
    bus.ld_data  = 8'hB2;
    cycle();
    idle();
    chk("mid_cnt", 32'(load_cnt), 2);
    do_reset("rst_load");
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hC1;
    bus.ld_last  = 1'b1;
    cycle();
    idle();
    cycle();
    rd(0, 8'hC1, "reload_0");
    rd(1, 8'h00, "reload_1");
    rd(40, 8'h00, "reload_40");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
